// File: rtl/filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : filter_pkg
//  Brief    : Shared types and constants for the sample sequencer and the
//             combinational difference-equation filter stage.
//  Revision : 1.0  initial release
// ============================================================================
package filter_pkg;

    // Sample width of the filter datapath
    localparam int N_DEFAULT = 10;

    // Unsigned midscale code, which represents zero signal
    localparam logic [N_DEFAULT-1:0] MIDSCALE = N_DEFAULT'(1) << (N_DEFAULT - 1);

    // Filter type encoding, shared with the filter stage
    localparam logic LPF = 1'b0;
    localparam logic HPF = 1'b1;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // Packed sample history: [0] = x[n], [1] = x[n-1]
    typedef logic [1:0][N_DEFAULT-1:0] sample_pair_t;

endpackage : filter_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Up-counter that saturates at all-ones, with synchronous clear.
//             A clear coincident with an increment yields a count of one.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, clamp at the top, clear wins over history but not over
    // an event arriving in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/filter_sample_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : filter_sample_ctrl
//  Brief    : Sample-rate sequencer in front of the combinational filter.
//             Accepts ADC samples, holds x[n], x[n-1], y[n-1], frequency and
//             type stable while the filter settles, captures the result as
//             feedback and hands it to the DAC over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module filter_sample_ctrl
    import filter_pkg::*;
#(
    parameter int          N             = 10,
    parameter int          SETTLE_CYCLES = 4,      // legal range 1..15
    parameter logic [15:0] F_RESET       = 16'd1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N-1:0]        adc_data,
    input  logic                adc_valid,
    input  logic [15:0]         f_in,
    input  logic                type_in,
    input  logic                clr_overrun,
    output logic [1:0][N-1:0]   x_out,
    output logic [N-1:0]        y_prev,
    output logic [15:0]         f_out,
    output logic                filt_type_out,
    input  logic [N-1:0]        filt_result,
    output logic [N-1:0]        dac_data,
    output logic                dac_valid,
    input  logic                dac_ready,
    output logic                overrun,
    output logic [7:0]          drop_count
);

    // Midscale code for this instance's width (zero signal level)
    localparam logic [N-1:0] MID         = {1'b1, {(N-1){1'b0}}};
    // Counter preload so capture lands SETTLE_CYCLES edges after accept
    localparam logic [3:0]   SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       drop;

    // Any strobe outside IDLE is a sample the filter cannot take
    assign drop = adc_valid && (state != IDLE);

    // Sequencer: filter inputs move only on the accept or capture edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            x_out[0]      <= MID;
            x_out[1]      <= MID;
            y_prev        <= MID;
            f_out         <= F_RESET;
            filt_type_out <= LPF;
            dac_data      <= MID;
            dac_valid     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (adc_valid) begin
                        x_out[0]      <= adc_data;
                        // A type change invalidates the old history
                        if (type_in != filt_type_out) begin
                            x_out[1] <= MID;
                            y_prev   <= MID;
                        end else begin
                            x_out[1] <= x_out[0];
                        end
                        f_out         <= f_in;
                        filt_type_out <= type_in;
                        cnt           <= SETTLE_LOAD;
                        state         <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (cnt == 4'd0) begin
                        y_prev    <= filt_result;
                        dac_data  <= filt_result;
                        dac_valid <= 1'b1;
                        state     <= OUTPUT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                OUTPUT: begin
                    if (dac_ready) begin
                        dac_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W (8)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (clr_overrun),
        .inc   (drop),
        .count (drop_count)
    );

endmodule : filter_sample_ctrl
`default_nettype wire

// File: tb/tb_filter_sample_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_filter_sample_ctrl
//  Brief    : Self-checking bench for filter_sample_ctrl with a behavioural
//             model of the sample history, latency and drop accounting.
//  Revision : 1.0  initial release
// ============================================================================
module tb_filter_sample_ctrl;

    localparam int          N   = 10;
    localparam int          S   = 4;
    localparam logic [N-1:0] MID = 10'd512;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [N-1:0]       adc_data;
    logic               adc_valid;
    logic [15:0]        f_in;
    logic               type_in;
    logic               clr_overrun;
    logic [1:0][N-1:0]  x_out;
    logic [N-1:0]       y_prev;
    logic [15:0]        f_out;
    logic               filt_type_out;
    logic [N-1:0]       filt_result;
    logic [N-1:0]       dac_data;
    logic               dac_valid;
    logic               dac_ready;
    logic               overrun;
    logic [7:0]         drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] m_x0, m_x1, m_y, m_dac;
    logic [15:0]  m_f;
    logic         m_type, m_ovr;
    int           m_drops;

    filter_sample_ctrl #(
        .N             (N),
        .SETTLE_CYCLES (S),
        .F_RESET       (16'd1000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .f_in          (f_in),
        .type_in       (type_in),
        .clr_overrun   (clr_overrun),
        .x_out         (x_out),
        .y_prev        (y_prev),
        .f_out         (f_out),
        .filt_type_out (filt_type_out),
        .filt_result   (filt_result),
        .dac_data      (dac_data),
        .dac_valid     (dac_valid),
        .dac_ready     (dac_ready),
        .overrun       (overrun),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_x0 = MID; m_x1 = MID; m_y = MID; m_dac = MID;
        m_f = 16'd1000; m_type = 1'b0; m_ovr = 1'b0; m_drops = 0;
    endtask

    // Compare every observable output against the model
    task automatic check_all_vs_model(input string tag, input logic exp_valid);
        checks++; if (x_out[0] !== m_x0) begin errors++; $display("FAIL %s x0 got %0d want %0d", tag, x_out[0], m_x0); end
        checks++; if (x_out[1] !== m_x1) begin errors++; $display("FAIL %s x1 got %0d want %0d", tag, x_out[1], m_x1); end
        checks++; if (y_prev !== m_y) begin errors++; $display("FAIL %s y_prev got %0d want %0d", tag, y_prev, m_y); end
        checks++; if (f_out !== m_f) begin errors++; $display("FAIL %s f_out got %0d want %0d", tag, f_out, m_f); end
        checks++; if (filt_type_out !== m_type) begin errors++; $display("FAIL %s type got %0b want %0b", tag, filt_type_out, m_type); end
        checks++; if (dac_valid !== exp_valid) begin errors++; $display("FAIL %s dac_valid got %0b want %0b", tag, dac_valid, exp_valid); end
        checks++; if (dac_data !== m_dac) begin errors++; $display("FAIL %s dac_data got %0d want %0d", tag, dac_data, m_dac); end
        checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL %s overrun got %0b want %0b", tag, overrun, m_ovr); end
        checks++; if (drop_count !== 8'(m_drops)) begin errors++; $display("FAIL %s drop_count got %0d want %0d", tag, drop_count, m_drops); end
    endtask

    // One full sample transaction starting and ending on a negedge in IDLE
    task automatic run_sample(input logic [N-1:0] data, input logic [15:0] f, input logic typ,
                              input logic [N-1:0] res, input int hold, input int ndrop, input bit handshake);
        int n;
        adc_data = data; f_in = f; type_in = typ; filt_result = res; adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
        if (typ != m_type) begin m_x1 = MID; m_y = MID; end
        else m_x1 = m_x0;
        m_x0 = data; m_f = f; m_type = typ;
        // Settle window: inputs to the filter must be frozen
        n = 0;
        while (!dac_valid && n < 40) begin
            check_all_vs_model("settle", 1'b0);
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != S) begin errors++; $display("FAIL latency got %0d want %0d", n, S); end
        m_y = res; m_dac = res;
        check_all_vs_model("capture", 1'b1);
        // Backpressure with optional dropped strobes
        for (int i = 0; i < hold; i++) begin
            adc_data = N'($urandom); f_in = 16'($urandom); type_in = 1'($urandom);
            adc_valid = (i < ndrop);
            @(negedge clk);
            if (adc_valid) begin
                m_ovr = 1'b1;
                if (m_drops < 255) m_drops++;
            end
            adc_valid = 1'b0;
            check_all_vs_model("hold", 1'b1);
        end
        if (handshake) begin
            dac_ready = 1'b1;
            @(negedge clk);
            dac_ready = 1'b0;
            check_all_vs_model("handshake", 1'b0);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_all_vs_model("reset", 1'b0);
    endtask

    task automatic test_clear();
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        m_ovr = 1'b0; m_drops = 0;
        check_all_vs_model("clear", dac_valid);
    endtask

    task automatic test_normal();
        run_sample(10'd700, 16'd1500, 1'b0, 10'd530, 0, 0, 1'b1);
        checks++; if (y_prev !== 10'd530) begin errors++; $display("FAIL normal y_prev got %0d want 530", y_prev); end
    endtask

    task automatic test_backpressure();
        run_sample(10'd650, 16'd1600, 1'b0, 10'd530, 10, 2, 1'b1);
        checks++; if (x_out[0] !== 10'd650 || x_out[1] !== 10'd700) begin errors++; $display("FAIL pair got %0d,%0d want 650,700", x_out[0], x_out[1]); end
        checks++; if (drop_count !== 8'd2 || overrun !== 1'b1) begin errors++; $display("FAIL drops got %0d/%0b want 2/1", drop_count, overrun); end
    endtask

    task automatic test_type_switch();
        run_sample(10'd600, 16'd1700, 1'b1, 10'd300, 0, 0, 1'b1);
        checks++; if (x_out[1] !== MID || filt_type_out !== 1'b1) begin errors++; $display("FAIL type_switch x1 got %0d type %0b want 512 1", x_out[1], filt_type_out); end
    endtask

    task automatic test_saturation();
        run_sample(10'd123, 16'd900, 1'b1, 10'd77, 0, 0, 1'b0);
        adc_valid = 1'b1;
        repeat (300) @(negedge clk);
        m_ovr = 1'b1; m_drops = 255;
        check_all_vs_model("saturate", 1'b1);
        clr_overrun = 1'b1;
        @(negedge clk);
        m_drops = 1;
        check_all_vs_model("clr_with_drop", 1'b1);
        adc_valid = 1'b0;
        @(negedge clk);
        clr_overrun = 1'b0;
        m_drops = 0; m_ovr = 1'b0;
        check_all_vs_model("clr_only", 1'b1);
        dac_ready = 1'b1;
        @(negedge clk);
        dac_ready = 1'b0;
        check_all_vs_model("sat_release", 1'b0);
    endtask

    task automatic test_reset_mid_settle();
        adc_data = 10'd900; f_in = 16'd2222; type_in = 1'b0; filt_result = 10'd11; adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all_vs_model("async_reset", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_all_vs_model("post_reset", 1'b0);
        end
        run_sample(10'd700, 16'd1500, 1'b0, 10'd530, 0, 0, 1'b1);
    endtask

    task automatic test_random();
        int hold;
        for (int k = 0; k < 25; k++) begin
            hold = int'($urandom_range(0, 5));
            run_sample(N'($urandom), 16'($urandom), 1'($urandom), N'($urandom), hold,
                       int'($urandom_range(0, hold)), 1'b1);
            if ($urandom_range(0, 3) == 0) test_clear();
        end
    endtask

    initial begin
        reset_n = 1'b0; adc_data = '0; adc_valid = 1'b0; f_in = '0; type_in = 1'b0;
        clr_overrun = 1'b0; filt_result = '0; dac_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_normal();
        test_backpressure();
        test_type_switch();
        test_clear();
        test_saturation();
        test_reset_mid_settle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_filter_sample_ctrl
`default_nettype wire
